// File: rtl/btn_pkg.sv
// Shared types and helpers for the debounced pushbutton pulse generator.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } btn_state_t;

  // One counter serves both debounce and repeat timing, so it is sized for the larger interval.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit; both stages reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both stages update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_pulse_gen.sv
// Debounces a raw pushbutton and emits a one-cycle strobe per accepted press.
// Optional auto-repeat while held is enabled by defining BTN_AUTOREPEAT_EN.
module button_pulse_gen
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic pulse_out,
  output logic btn_level
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          btn_s;
  logic          accept;
  logic          rpt_fire;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_s)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = DEB_PRESS;
          cnt_d   = '0;
        end
      end
      DEB_PRESS: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_LAST) begin
          state_d = PRESSED;
          accept  = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d = DEB_RELEASE;
          cnt_d   = '0;
        end
      end
      DEB_RELEASE: begin
        if (btn_s) begin
          state_d = PRESSED;
        end else if (cnt_q >= DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_CYCLES - 1);

  logic [CW-1:0] rpt_q;
  logic          holding;

  // Repeats only while the button is still seen held; any dip toward release clears the interval.
  assign holding  = (state_q == PRESSED) && btn_s;
  assign rpt_fire = holding && (rpt_q >= RPT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_q <= '0;
    end else if (!holding || rpt_fire) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_q + 1'b1;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // NOTE: only control state is reset here; there is no memory array needing a reset sweep.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pulse_out <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pulse_out <= accept | rpt_fire;
      btn_level <= (state_d == PRESSED) || (state_d == DEB_RELEASE);
    end
  end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed bench for button_pulse_gen with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
module tb_button_pulse_gen;

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic pulse_out;
  logic btn_level;

  int total = 0;
  int bad   = 0;

  logic        prev_pulse = 1'b0;
  logic        double_seen = 1'b0;
  logic [63:0] pm, lm;
  logic [63:0] exp_p;

  button_pulse_gen #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_CYCLES   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .pulse_out (pulse_out),
    .btn_level (btn_level)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ones(input int n);
    return (64'h1 << n) - 64'h1;
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Applies pattern[i] before edge i, samples outputs 1 time unit after that edge into bit i.
  task automatic run(input logic [63:0] pattern, input int n,
                     output logic [63:0] p_mask, output logic [63:0] l_mask);
    p_mask = '0;
    l_mask = '0;
    for (int i = 0; i < n; i++) begin
      btn_in = pattern[i];
      @(posedge clk);
      #1;
      p_mask[i] = pulse_out;
      l_mask[i] = btn_level;
      if (pulse_out && prev_pulse) double_seen = 1'b1;
      prev_pulse = pulse_out;
    end
  endtask

  initial begin
    reset  = 1'b0;
    btn_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pulse", {63'd0, pulse_out}, 64'd0);
    check("reset_level", {63'd0, btn_level}, 64'd0);
    reset = 1'b1;
    run(64'd0, 5, pm, lm);

    // Clean press held 20 cycles, then release
    run(ones(20), 20, pm, lm);
`ifdef BTN_AUTOREPEAT_EN
    exp_p = (64'h1 << 6) | (64'h1 << 14);
`else
    exp_p = 64'h1 << 6;
`endif
    check("clean_pulse", pm, exp_p);
    check("clean_level", lm, ones(20) & ~ones(6));
    run(64'd0, 10, pm, lm);
    check("release_pulse", pm, 64'd0);
    check("release_level", lm, ones(6));

    // Every-cycle bounce never accepted
    run(64'h155, 20, pm, lm);
    check("bounce_pulse", pm, 64'd0);
    check("bounce_level", lm, 64'd0);

    // Held press with a 2-cycle dropout
    run(ones(12) | (ones(20) & ~ones(14)), 32, pm, lm);
    check("dropout_pulse", pm, 64'h1 << 6);
    check("dropout_level", lm, ones(26) & ~ones(6));

    // Reset during DEB_PRESS, released with the button still held
    run(ones(4), 4, pm, lm);
    check("predeb_pulse", pm, 64'd0);
    reset = 1'b0;
    #2;
    check("async_deb_level", {63'd0, btn_level}, 64'd0);
    run(ones(5), 5, pm, lm);
    check("inreset_pulse", pm, 64'd0);
    check("inreset_level", lm, 64'd0);
    reset = 1'b1;
    run(ones(12), 12, pm, lm);
    check("postreset_pulse", pm, 64'h1 << 6);
    check("postreset_level", lm, ones(12) & ~ones(6));
    run(64'd0, 10, pm, lm);
    check("settle_level", lm, ones(6));

    // Long hold: auto-repeat when enabled, single pulse otherwise
    run(ones(37), 37, pm, lm);
`ifdef BTN_AUTOREPEAT_EN
    exp_p = (64'h1 << 6) | (64'h1 << 14) | (64'h1 << 22) | (64'h1 << 30);
`else
    exp_p = 64'h1 << 6;
`endif
    check("hold_pulse", pm, exp_p);
    check("hold_level", lm, ones(37) & ~ones(6));

    // Reset while PRESSED drops the level without waiting for a clock edge
    reset = 1'b0;
    #2;
    check("async_press_level", {63'd0, btn_level}, 64'd0);
    run(ones(3), 3, pm, lm);
    reset = 1'b1;
    run(ones(10), 10, pm, lm);
    check("fresh_pulse", pm, 64'h1 << 6);
    check("fresh_level", lm, ones(10) & ~ones(6));
    run(64'd0, 10, pm, lm);
    check("final_level", lm, ones(6));

    check("no_double_pulse", {63'd0, double_seen}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_pulse_gen.md
BUTTON_PULSE_GEN -- requirements
Module: button_pulse_gen

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable synchronized samples needed to accept a press or release; legal range 2..65535.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 5000000: auto-repeat interval in cycles; legal range 2..2^24-1; used only under BTN_AUTOREPEAT_EN.
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port btn_in  input  1  raw pushbutton, asynchronous, bouncy; 1 = pressed.
REQ-006 SHALL have port pulse_out  output  1  registered one-cycle enable strobe per accepted press; drives the enable of the 2-bit result register.
REQ-007 SHALL have port btn_level  output  1  registered debounced button level.

Function
REQ-008 SHALL pass btn_in through a 2-flop synchronizer; its second stage is btn_s, and no other logic samples btn_in.
REQ-009 SHALL implement FSM states IDLE, DEB_PRESS, PRESSED, DEB_RELEASE plus one shared counter cnt, sized to the larger of the two parameters.
REQ-010 In IDLE: btn_s=1 -> DEB_PRESS with cnt=0; otherwise stay.
REQ-011 In DEB_PRESS: btn_s=0 -> IDLE, no pulse (bounce rejected); btn_s=1 with cnt<DEBOUNCE_CYCLES-1 -> cnt+1; btn_s=1 with cnt=DEBOUNCE_CYCLES-1 -> PRESSED, pulse_out=1.
REQ-012 In PRESSED: btn_s=0 -> DEB_RELEASE with cnt=0; otherwise stay.
REQ-013 In DEB_RELEASE: btn_s=1 -> PRESSED, no pulse; btn_s=0 with cnt=DEBOUNCE_CYCLES-1 -> IDLE; otherwise cnt+1.
REQ-014 pulse_out SHALL be high for exactly one cycle per IDLE->PRESSED acceptance and SHALL never be high two consecutive cycles.
REQ-015 Latency: btn_in rising before edge k and held stable -> pulse_out high in the cycle following edge k+DEBOUNCE_CYCLES+2.
REQ-016 btn_level SHALL be 1 exactly when the state is PRESSED or DEB_RELEASE.
REQ-017 cnt SHALL saturate and never wrap; an illegal state encoding SHALL return to IDLE with both outputs 0.

Reset
REQ-018 reset=0 SHALL immediately force state IDLE, cnt=0, both synchronizer flops 0, pulse_out=0, btn_level=0, regardless of clk.
REQ-019 Reset asserted mid-debounce or mid-press SHALL abort the pending pulse; after release, a still-held button SHALL be re-debounced from IDLE and produce one fresh pulse.

Configuration
REQ-020 Macro BTN_AUTOREPEAT_EN defined: while in PRESSED, a repeat counter cleared on PRESSED entry SHALL emit one pulse_out every REPEAT_CYCLES cycles; it SHALL be cleared on leaving PRESSED and SHALL be held (no pulses) in DEB_RELEASE.
REQ-021 Macro BTN_AUTOREPEAT_EN undefined: no repeat counter logic is synthesized; exactly one pulse per press.

Structure
REQ-022 The FSM state enum type (btn_state_t) SHALL live in the shared package btn_pkg.
REQ-023 The synchronizer SHALL be the sub-module sync_2ff (1-bit, clk and reset, reset value 0).

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8)
REQ-024 Clean press at edge 0, held 20 cycles -> pulse_out high only in the cycle after edge 6; btn_level 1 from that cycle.
REQ-025 btn_in toggling 1,0,1,0 every cycle for 10 cycles, then 0 -> pulse_out never asserted; btn_level stays 0.
REQ-026 Held press with a 2-cycle dropout -> exactly one pulse; btn_level does not fall.
REQ-027 Assert reset=0 during DEB_PRESS, release while btn_in=1 -> no pulse during reset; one pulse 7 edges after release.
REQ-028 With BTN_AUTOREPEAT_EN, hold 30 cycles after acceptance -> pulses at acceptance, +8, +16 and +24 cycles; without the macro -> acceptance pulse only.
